// File: rtl/data_mem_access_unit.sv
// Load/store unit between the MIPS datapath and the data-memory bus.
// Issues one registered req/ack bus cycle per aligned access, stalls the
// datapath until the access resolves, and returns extended load data.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no bus cycle; accept a new aligned access or flag misalign
// S_WAIT | bus_req held, waiting for bus_ack or timeout
// S_DONE | access resolved; stall released so the datapath commits
module data_mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        addr_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_accept;
  logic        w_ack_done;
  logic        w_timeout;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;

  logic [15:0] r_cnt;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_rdata;
  logic        r_addr_err;
  logic        r_bus_err;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;

  // Picks the addressed lane out of the read word and extends it.
  function automatic logic [31:0] f_extract(input logic [31:0] d, input logic [1:0] lane,
                                            input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lane[1] ? d[31:16] : d[15:0];
    case (sz)
      2'b00:   f_extract = {{24{~uns & b[7]}}, b};
      2'b01:   f_extract = {{16{~uns & h[15]}}, h};
      default: f_extract = d;
    endcase
  endfunction

  assign w_misaligned = mem_req & (((mem_size == 2'b01) & addr[0]) |
                                   (mem_size[1] & (addr[1:0] != 2'b00)));

  // Reset is folded in so stall reads 0 while rst is held low.
  assign stall = rst & mem_req & ~w_misaligned & (r_state != S_DONE);

  // Byte enables and lane-replicated store data for the incoming access.
  always_comb begin
    w_be        = 4'b1111;
    w_wdata_rep = wdata;
    case (mem_size)
      2'b00: begin
        w_be        = 4'b0001 << addr[1:0];
        w_wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_be        = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state decode; ack on the final WAIT cycle beats the timeout.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_ack_done   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_req && !w_misaligned) begin
          w_next_state = S_WAIT;
          w_accept     = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus_ack) begin
          w_next_state = S_DONE;
          w_ack_done   = 1'b1;
        end else if (r_cnt == 16'(TIMEOUT - 1)) begin
          w_next_state = S_DONE;
          w_timeout    = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Bus outputs, load data, error pulses and the WAIT cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_lane      <= '0;
      r_size      <= '0;
      r_uns       <= 1'b0;
      r_rdata     <= '0;
      r_addr_err  <= 1'b0;
      r_bus_err   <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
    end else begin
      r_addr_err <= (r_state == S_IDLE) & w_misaligned;
      r_bus_err  <= w_timeout;
      if (w_accept) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= mem_we;
        r_bus_addr  <= {addr[31:2], 2'b00};
        r_bus_be    <= w_be;
        r_bus_wdata <= w_wdata_rep;
        r_lane      <= addr[1:0];
        r_size      <= mem_size;
        r_uns       <= mem_uns;
        r_cnt       <= '0;
      end else if (w_ack_done || w_timeout) begin
        r_bus_req <= 1'b0;
        r_bus_we  <= 1'b0;
        r_bus_be  <= '0;
        if (!r_bus_we)
          r_rdata <= w_ack_done ? f_extract(bus_rdata, r_lane, r_size, r_uns) : '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 16'd1;
      end else if (r_state == S_DONE) begin
        r_cnt <= '0;
      end
    end
  end

  assign rdata     = r_rdata;
  assign addr_err  = r_addr_err;
  assign bus_err   = r_bus_err;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Bench for data_mem_access_unit: directed table, random accesses against
// an arithmetic reference model, and reset / stray-ack sequences.
module tb_data_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_uns;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, addr_err, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_uns(mem_uns), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .addr_err(addr_err), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          ack_at;     // WAIT cycle (1-based) in which ack is given, 0 = never
    int          exp_stall;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    int          stall_cyc;
    int          req_cyc;
    logic [3:0]  be;
    logic [31:0] ba;
    logic [31:0] bwd;
    logic        bwe;
    logic        aerr;
    logic        berr;
    logic [31:0] rdata;
  } res_t;

  logic [31:0] m_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: what one access should look like, from the rules alone.
  function automatic res_t model(input vec_t v, input logic [31:0] prev_rdata);
    res_t r;
    logic [31:0] val;
    int waits;
    logic mis;
    mis = (v.sz == 2'd1 && v.a[0]) || (v.sz >= 2'd2 && v.a[1:0] != 0);
    r = '{default: 0};
    r.rdata = prev_rdata;
    if (mis) begin
      r.aerr = 1'b1;
      return r;
    end
    waits       = (v.ack_at >= 1 && v.ack_at <= TMO) ? v.ack_at : TMO;
    r.stall_cyc = waits + 1;
    r.req_cyc   = waits;
    r.berr      = !(v.ack_at >= 1 && v.ack_at <= TMO);
    r.ba        = v.a - (v.a % 4);
    r.bwe       = v.we;
    if (v.sz == 2'd0) begin
      r.be  = 4'(1 << (v.a % 4));
      r.bwd = (v.wd % 256) * 32'h0101_0101;
      val   = (v.rd >> (8 * (v.a % 4))) % 256;
      if (!v.uns && val >= 128) val = val - 256;
    end else if (v.sz == 2'd1) begin
      r.be  = ((v.a % 4) >= 2) ? 4'd12 : 4'd3;
      r.bwd = (v.wd % 65536) * 32'h0001_0001;
      val   = (v.rd >> (16 * ((v.a % 4) / 2))) % 65536;
      if (!v.uns && val >= 32768) val = val - 65536;
    end else begin
      r.be  = 4'd15;
      r.bwd = v.wd;
      val   = v.rd;
    end
    if (!v.we) r.rdata = r.berr ? 32'd0 : val;
    return r;
  endfunction

  // Drives one instruction until it commits, acking the bus when asked to.
  task automatic run_access(input vec_t v, output res_t o, output logic [3:0] be_done,
                            output logic hung);
    @(negedge clk);
    mem_req = 1'b1; mem_we = v.we; mem_size = v.sz; mem_uns = v.uns;
    addr = v.a; wdata = v.wd; bus_rdata = v.rd; bus_ack = 1'b0;
    o = '{default: 0};
    be_done = 4'hx;
    hung = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!stall) begin
        o.berr  = bus_err;
        be_done = bus_be;
        hung    = 1'b0;
        break;
      end
      o.stall_cyc++;
      if (bus_req) begin
        o.req_cyc++;
        o.be  = bus_be;
        o.ba  = bus_addr;
        o.bwd = bus_wdata;
        o.bwe = bus_we;
        bus_ack = (o.req_cyc == v.ack_at);
      end else begin
        bus_ack = 1'b0;
      end
      @(negedge clk);
    end
    bus_ack = 1'b0;
    @(posedge clk);
    #1;
    o.aerr  = addr_err;
    o.rdata = rdata;
    mem_req = 1'b0;
  endtask

  task automatic do_and_check(input vec_t v, input string tag, input logic use_table);
    res_t got, exp;
    logic [3:0] be_done;
    logic hung;
    exp = model(v, m_rdata);
    run_access(v, got, be_done, hung);
    check({tag, " no_hang"}, 32'(hung), 32'd0);
    check({tag, " stall_cycles"}, 32'(got.stall_cyc), 32'(exp.stall_cyc));
    check({tag, " req_cycles"}, 32'(got.req_cyc), 32'(exp.req_cyc));
    check({tag, " bus_be"}, 32'(got.be), 32'(exp.be));
    check({tag, " bus_addr"}, got.ba, exp.ba);
    check({tag, " bus_wdata"}, got.bwd, exp.bwd);
    check({tag, " bus_we"}, 32'(got.bwe), 32'(exp.bwe));
    check({tag, " addr_err"}, 32'(got.aerr), 32'(exp.aerr));
    check({tag, " bus_err"}, 32'(got.berr), 32'(exp.berr));
    check({tag, " be_after_wait"}, 32'(be_done), 32'd0);
    check({tag, " rdata"}, got.rdata, exp.rdata);
    if (use_table) begin
      check({tag, " tbl_stall"}, 32'(got.stall_cyc), 32'(v.exp_stall));
      check({tag, " tbl_be"}, 32'(got.be), 32'(v.exp_be));
      check({tag, " tbl_rdata"}, got.rdata, v.exp_rdata);
    end
    m_rdata = exp.rdata;
  endtask

  vec_t tbl[11];

  initial begin
    vec_t v;
    tbl[0]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3, 4, 4'hF, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h8A000000, 1, 2, 4'h8, 32'hFFFFFF8A};
    tbl[2]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h8A000000, 1, 2, 4'h8, 32'h0000008A};
    tbl[3]  = '{1'b1, 2'b01, 1'b0, 32'h22, 32'h1234ABCD, 32'h0, 1, 2, 4'hC, 32'h0000008A};
    tbl[4]  = '{1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h5555AAAA, 1, 0, 4'h0, 32'h0000008A};
    tbl[5]  = '{1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h11223344, 0, 5, 4'hF, 32'h00000000};
    tbl[6]  = '{1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'h55667788, 4, 5, 4'hF, 32'h55667788};
    tbl[7]  = '{1'b0, 2'b01, 1'b0, 32'h46, 32'h0, 32'h9ABC0000, 2, 3, 4'hC, 32'hFFFF9ABC};
    tbl[8]  = '{1'b1, 2'b00, 1'b0, 32'h01, 32'h000000A5, 32'h0, 2, 3, 4'h2, 32'hFFFF9ABC};
    tbl[9]  = '{1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 32'h0, 1, 0, 4'h0, 32'hFFFF9ABC};
    tbl[10] = '{1'b0, 2'b11, 1'b0, 32'h08, 32'h0, 32'h0BADF00D, 1, 2, 4'hF, 32'h0BADF00D};

    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_uns = 1'b0;
    addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    m_rdata = '0;
    #1;
    check("reset rdata", rdata, 32'd0);
    check("reset bus_req", 32'(bus_req), 32'd0);
    check("reset bus_be", 32'(bus_be), 32'd0);
    check("reset errs", 32'({addr_err, bus_err, bus_we}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) do_and_check(tbl[i], $sformatf("tbl%0d", i), 1'b1);

    // Stray ack while idle must not touch rdata or start a bus cycle.
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("idle_ack rdata", rdata, m_rdata);
    check("idle_ack bus_req", 32'(bus_req), 32'd0);

    for (int i = 0; i < 60; i++) begin
      v.we = 1'($urandom); v.sz = 2'($urandom); v.uns = 1'($urandom);
      v.a = $urandom; v.wd = $urandom; v.rd = $urandom;
      v.ack_at = int'($urandom_range(0, TMO));
      v.exp_stall = 0; v.exp_be = '0; v.exp_rdata = '0;
      do_and_check(v, $sformatf("rnd%0d", i), 1'b0);
    end

    // Asynchronous reset in the middle of a WAIT.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; addr = 32'h100; bus_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("midwait bus_req before rst", 32'(bus_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("midwait rst bus_req", 32'(bus_req), 32'd0);
    check("midwait rst stall", 32'(stall), 32'd0);
    check("midwait rst rdata", rdata, 32'd0);
    m_rdata = '0;
    mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    v = '{1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'h13579BDF, 1, 2, 4'hF, 32'h13579BDF};
    do_and_check(v, "post_rst", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
